// File: rtl/am_search_controller.sv
// am_search_controller: streams a query HV to the AM AND array, scores each class by overlap, then picks the argmax
module am_search_controller #(
  parameter int DIMS_PER_CC     = 100,
  parameter int SEQ_CYCLE_COUNT = 10,
  parameter int NUM_CLASSES     = 26,
  parameter int SCORE_W         = $clog2(DIMS_PER_CC*SEQ_CYCLE_COUNT+1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 q_valid,
  output logic                                 q_ready,
  input  logic [DIMS_PER_CC*SEQ_CYCLE_COUNT-1:0] q_hv,
  output logic                                 comparing_query_hv_with_class_hv,
  output logic [3:0]                           query_ctr,
  output logic [DIMS_PER_CC-1:0]               query_hv_segment,
  input  logic [DIMS_PER_CC-1:0]               and_array_out [0:NUM_CLASSES-1],
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [4:0]                           res_class,
  output logic [SCORE_W-1:0]                   res_score
);
  typedef enum logic [1:0] {IDLE, COMPARE, ARGMAX, DONE} state_t;
  state_t state;
  logic [DIMS_PER_CC*SEQ_CYCLE_COUNT-1:0] q_lat;
  logic [SCORE_W-1:0] acc [NUM_CLASSES];
  logic [4:0] idx;
  function automatic logic [SCORE_W-1:0] popcount(input logic [DIMS_PER_CC-1:0] v);
    popcount = '0;
    for (int b = 0; b < DIMS_PER_CC; b++) popcount = popcount + SCORE_W'(v[b]);
  endfunction
  // Control FSM: accept query, stream segments while accumulating overlaps, sequential argmax, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q_ready <= 1'b0;
      q_lat <= '0;
      comparing_query_hv_with_class_hv <= 1'b0;
      query_ctr <= '0;
      query_hv_segment <= '0;
      idx <= '0;
      res_valid <= 1'b0;
      res_class <= '0;
      res_score <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          q_ready <= 1'b1;
          if (q_valid && q_ready) begin
            q_ready <= 1'b0;
            q_lat <= q_hv;
            query_hv_segment <= q_hv[DIMS_PER_CC-1:0];
            comparing_query_hv_with_class_hv <= 1'b1;
            query_ctr <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= acc[i] + popcount(and_array_out[i]);
          if (query_ctr == 4'(SEQ_CYCLE_COUNT-1)) begin
            comparing_query_hv_with_class_hv <= 1'b0;
            query_ctr <= '0;
            query_hv_segment <= '0;
            idx <= '0;
            state <= ARGMAX;
          end else begin
            query_ctr <= query_ctr + 4'd1;
            q_lat <= q_lat >> DIMS_PER_CC;
            query_hv_segment <= q_lat[2*DIMS_PER_CC-1:DIMS_PER_CC];
          end
        end
        ARGMAX: begin
          if (idx == 5'd0 || acc[idx] > res_score) begin
            res_score <= acc[idx];
            res_class <= idx;
          end
          if (idx == 5'(NUM_CLASSES-1)) begin
            res_valid <= 1'b1;
            state <= DONE;
          end else idx <= idx + 5'd1;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            q_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_am_search_controller.sv
// tb_am_search_controller: directed scoreboard bench for the AM search controller
module tb_am_search_controller;
  localparam int D = 100, S = 10, N = 26, W = 10;
  logic clk = 1'b0, rst = 1'b1, q_valid = 1'b0, res_ready = 1'b0;
  logic q_ready, comparing, res_valid;
  logic [D*S-1:0] q_hv = '0;
  logic [3:0] query_ctr;
  logic [D-1:0] seg;
  logic [D-1:0] and_out [0:N-1];
  logic [4:0] res_class;
  logic [W-1:0] res_score;
  int ones [N];
  int total = 0, bad = 0;
  typedef struct {int cls; int score;} exp_t;
  exp_t sb [$];
  exp_t e;

  am_search_controller dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_ready(q_ready), .q_hv(q_hv),
    .comparing_query_hv_with_class_hv(comparing), .query_ctr(query_ctr),
    .query_hv_segment(seg), .and_array_out(and_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_class(res_class), .res_score(res_score)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] mask(input int n);
    mask = '0;
    for (int b = 0; b < n; b++) mask[b] = 1'b1;
  endfunction

  // AND-array model: class i returns ones[i] set bits every cycle
  always_comb for (int i = 0; i < N; i++) and_out[i] = mask(ones[i]);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop expected result on every result handshake
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = sb.pop_front();
        chk("res_class", res_class, e.cls);
        chk("res_score", res_score, e.score);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [D*S-1:0] hv, input int cls, input int score);
    sb.push_back('{cls, score});
    q_hv = hv;
    q_valid = 1'b1;
    for (int t = 0; t < 100 && !q_ready; t++) tick();
    chk("q_ready_timeout", q_ready, 1);
    tick();
    q_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 100 && !res_valid; t++) tick();
    chk("res_valid_timeout", res_valid, 1);
  endtask

  task automatic take();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic set_ones(input int modv, input int cls_a, input int val_a, input int cls_b, input int val_b);
    for (int i = 0; i < N; i++) ones[i] = (modv == 0) ? 0 : i % modv;
    ones[cls_a] = val_a;
    ones[cls_b] = val_b;
  endtask

  initial begin
    logic [D*S-1:0] hv;
    logic [D-1:0] pat;
    logic [3:0] k4;
    int seen;
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [D*S-1:0] hv;
    logic [D-1:0] pat;
    logic [3:0] k4;
    int seen;
    set_ones(0, 0, 0, 0, 0);
    repeat (3) begin
      tick();
      chk("q_ready_in_reset", q_ready, 0);
    end
    chk("rst_res_valid", res_valid, 0);
    chk("rst_comparing", comparing, 0);
    chk("rst_query_ctr", query_ctr, 0);
    chk("rst_segment", seg, 0);
    chk("rst_res_class", res_class, 0);
    chk("rst_res_score", res_score, 0);
    rst = 1'b0;
    tick();
    chk("q_ready_after_reset", q_ready, 1);
    repeat (3) tick();
    chk("idle_comparing", comparing, 0);

    // Streaming + scoring: class 7 = 50 ones per cycle
    for (int k = 0; k < S; k++) begin
      k4 = 4'(k);
      hv[k*D +: D] = {25{k4}};
    end
    set_ones(21, 7, 50, 7, 50);
    send(hv, 7, 500);
    for (int k = 0; k < S; k++) begin
      k4 = 4'(k);
      pat = {25{k4}};
      chk("stream_comparing", comparing, 1);
      chk("stream_query_ctr", query_ctr, k);
      chk("stream_segment", seg, pat);
      tick();
    end
    chk("stream_end_comparing", comparing, 0);
    chk("stream_end_query_ctr", query_ctr, 0);
    chk("stream_end_segment", seg, 0);
    repeat (25) tick();
    chk("latency_not_yet", res_valid, 0);
    tick();
    chk("latency_36", res_valid, 1);
    take();
    chk("q_ready_after_take", q_ready, 1);
    chk("res_valid_after_take", res_valid, 0);

    // Tie between classes 3 and 12 goes to the lower index
    set_ones(4, 3, 4, 12, 4);
    send({10{100'h5}}, 3, 40);
    wait_done();
    take();

    // All-zero AND results
    set_ones(0, 0, 0, 0, 0);
    send({10{100'hF}}, 0, 0);
    wait_done();
    take();

    // Backpressure: result held, second query not accepted
    set_ones(5, 20, 10, 20, 10);
    send({10{100'h3}}, 20, 100);
    wait_done();
    q_valid = 1'b1;
    q_hv = {10{100'h9}};
    set_ones(7, 25, 7, 25, 7);
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_class", res_class, 20);
      chk("bp_res_score", res_score, 100);
      chk("bp_q_ready", q_ready, 0);
      chk("bp_comparing", comparing, 0);
    end
    sb.push_back('{25, 70});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_q_ready_next", q_ready, 1);
    chk("bp_res_valid_drop", res_valid, 0);
    tick();
    chk("bp_accept_q_ready", q_ready, 0);
    chk("bp_accept_comparing", comparing, 1);
    q_valid = 1'b0;
    wait_done();
    take();

    // Reset in the middle of COMPARE discards partial scores
    set_ones(1, 2, 90, 5, 90);
    for (int i = 0; i < N; i++) ones[i] = 60;
    rst = 1'b0;
    q_hv = {10{100'h1}};
    q_valid = 1'b1;
    for (int t = 0; t < 100 && !q_ready; t++) tick();
    chk("mid_q_ready", q_ready, 1);
    tick();
    q_valid = 1'b0;
    repeat (4) tick();
    chk("mid_query_ctr", query_ctr, 4);
    rst = 1'b1;
    tick();
    chk("mid_rst_comparing", comparing, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_q_ready", q_ready, 0);
    rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (res_valid) seen++;
    end
    chk("mid_no_res_valid", seen, 0);
    set_ones(20, 2, 30, 2, 30);
    send({10{100'h7}}, 2, 300);
    wait_done();
    take();
    repeat (2) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
